// File: rtl/ps2_tx_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package ps2_tx_pkg;

    // Transmitter sequencing states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_WAIT_FIRST,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } tx_state_e;

    // Bits shifted out after the start bit: 8 data, parity, stop.
    localparam int FRAME_BITS = 10;

    // Convert a microsecond interval to system clock cycles.
    // 64-bit math keeps long timeouts at high clock rates from overflowing.
    function automatic longint unsigned us_to_cycles(input longint unsigned freq,
                                                     input longint unsigned us);
        return (freq * us) / 64'd1000000;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pad plus a falling-edge strobe.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic pad_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resample the pad; flops reset to 1 (idle line level) so reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pad_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device
// clock falls, ACK sampling and timeout supervision.
//
// Handshake: a byte is transferred on any clock edge where tx_valid and
// tx_ready are both 1. tx_ready is 1 only in IDLE; tx_valid while not ready
// is ignored and nothing is queued. tx_data must be stable while tx_valid is 1.
module ps2_host_tx import ps2_tx_pkg::*; #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int INHIBIT_US    = 120,
    parameter int FIRST_EDGE_US = 15000,
    parameter int FRAME_US      = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] dbg_state
);

    localparam int INHIBIT_CYCLES    = int'(us_to_cycles(CLK_FREQ_HZ, INHIBIT_US));
    localparam int FIRST_EDGE_CYCLES = int'(us_to_cycles(CLK_FREQ_HZ, FIRST_EDGE_US));
    localparam int FRAME_CYCLES      = int'(us_to_cycles(CLK_FREQ_HZ, FRAME_US));
    localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);
    localparam int EDGE_W  = $clog2(FIRST_EDGE_CYCLES + 1);
    localparam int FRAME_W = $clog2(FRAME_CYCLES + 1);

    localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
    // The edge budget counts the START and FAIL cycles too, so the error
    // pulse lands exactly FIRST_EDGE_CYCLES after START.
    localparam logic [EDGE_W-1:0]  EDGE_LAST  = EDGE_W'(FIRST_EDGE_CYCLES - 2);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);

    tx_state_e          state_q, state_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [9:0]         shreg_q, shreg_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic               data_bit_q, data_bit_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;
    logic frame_expired;

    ps2_line_sync u_clk_sync (
        .clock  (clock),
        .reset  (reset),
        .pad_i  (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clock  (clock),
        .reset  (reset),
        .pad_i  (ps2_data_in),
        .sync_o (dat_sync),
        .fall_o (dat_fall_unused)
    );

    assign frame_expired = (frame_cnt_q == FRAME_LAST);

    // Next-state, counters, shift register and line drive for the transmit sequence.
    always_comb begin
        state_d     = state_q;
        inh_cnt_d   = inh_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        frame_cnt_d = frame_cnt_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        data_bit_d  = data_bit_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_d    = {1'b1, ~^tx_data, tx_data};
                    bitcnt_d   = 4'd0;
                    inh_cnt_d  = '0;
                    data_bit_d = 1'b0;
                    state_d    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    state_d = S_START;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                edge_cnt_d  = EDGE_W'(1);
                state_d     = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    data_bit_d  = ~shreg_q[0];
                    shreg_d     = {1'b1, shreg_q[9:1]};
                    bitcnt_d    = 4'd1;
                    frame_cnt_d = '0;
                    state_d     = S_SHIFT;
                end else if (edge_cnt_q == EDGE_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                end
            end
            S_SHIFT: begin
                ps2_data_oe = data_bit_q;
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                if (frame_expired) begin
                    state_d = S_FAIL;
                end else if (clk_fall) begin
                    // Stop bit shifts in as 1, so presenting it releases data.
                    data_bit_d = ~shreg_q[0];
                    shreg_d    = {1'b1, shreg_q[9:1]};
                    bitcnt_d   = (bitcnt_q == 4'(FRAME_BITS)) ? bitcnt_q : bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                if (frame_expired) begin
                    state_d = S_FAIL;
                end else if (clk_fall) begin
                    state_d = dat_sync ? S_FAIL : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                if (frame_expired) begin
                    state_d = S_FAIL;
                end else if (clk_sync && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FAIL: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and pulse registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            inh_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            frame_cnt_q <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= 4'd0;
            data_bit_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            inh_cnt_q   <= inh_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            data_bit_q  <= data_bit_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign tx_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign tx_done   = done_q;
    assign tx_error  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on wired-AND lines, acceptance-driven
// scoreboard, pulse monitor, directed and randomized frames.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ  = 50_000_000;
  localparam int INH_US  = 2;
  localparam int EDGE_US = 100;
  localparam int FRM_US  = 2000;
  localparam int INHIBIT_CYCLES    = CLK_HZ / 1_000_000 * INH_US;
  localparam int FIRST_EDGE_CYCLES = CLK_HZ / 1_000_000 * EDGE_US;
  localparam int HALF = 500;  // 10 us device clock half-period

  localparam int DEV_ACK   = 0;
  localparam int DEV_NACK  = 2;
  localparam int DEV_ABORT = 3;

  localparam logic [1:0] K_NONE      = 2'd0;
  localparam logic [1:0] K_DONE      = 2'd1;
  localparam logic [1:0] K_ERR_FRAME = 2'd2;
  localparam logic [1:0] K_ERR       = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic [2:0] dbg_state;

  always #10 clock = ~clock;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .INHIBIT_US   (INH_US),
    .FIRST_EDGE_US(EDGE_US),
    .FRAME_US     (FRM_US)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [12:0] exp_q[$];   // {kind, expected 11-bit line frame}
  logic [10:0] seen_q[$];  // frames observed by the device model
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int start_cyc = 0, clk_run = 0, last_inh = 0;
  logic prev_start = 1'b0;
  logic [1:0] exp_kind_next = K_NONE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: line bits in order start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    int v;
    ones = 0;
    v = int'(b);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((v / (1 << i)) % 2) == 1;
      ones += (v / (1 << i)) % 2;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Acceptance monitor: every accepted byte pushes its expected outcome.
  always @(posedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      if (exp_kind_next != K_NONE) exp_q.push_back({exp_kind_next, ref_frame(tx_data)});
    end
  end

  // Output monitor: pops an expectation whenever a done/error pulse appears.
  always @(negedge clock) begin
    logic [12:0] e;
    if (reset) begin
      clk_run = 0;
      prev_start = 1'b0;
    end else begin
      if (ps2_clk_oe) clk_run++;
      else if (clk_run != 0) begin
        last_inh = clk_run;
        clk_run = 0;
      end
      if (ps2_clk_oe && ps2_data_oe && !prev_start) start_cyc = cyc;
      prev_start = ps2_clk_oe && ps2_data_oe;
      if (tx_done || tx_error) begin
        if (tx_done) begin done_cnt++; done_cyc = cyc; end
        if (tx_error) begin err_cnt++; err_cyc = cyc; end
        check("pulse_exclusive", 32'(tx_done & tx_error), 0);
        check("pulse_ready", 32'(tx_ready), 1);
        check("pulse_clk_oe", 32'(ps2_clk_oe), 0);
        check("pulse_data_oe", 32'(ps2_data_oe), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse done=%0b error=%0b cycle=%0d", tx_done, tx_error, cyc);
        end else begin
          e = exp_q.pop_front();
          check("result_kind", tx_done ? 32'd1 : 32'd2, (e[12:11] == K_DONE) ? 32'd1 : 32'd2);
          if (e[12:11] != K_ERR) begin
            if (seen_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_missing no device frame recorded cycle=%0d", cyc);
            end else begin
              check("frame_bits", 32'(seen_q.pop_front()), 32'(e[10:0]));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    @(negedge clock);
    while (!tx_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check("send_ready_wait", 32'(n < 20000), 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    if (hold) tx_data = 8'h00;
    else tx_valid = 1'b0;
    @(negedge clock);
    check("accept_busy", 32'(busy), 1);
    check("accept_clk_oe", 32'(ps2_clk_oe), 1);
    check("accept_ready", 32'(tx_ready), 0);
  endtask

  // Device side of one frame: waits for request-to-send, clocks bits in at
  // rising edges, then ACKs (or not). DEV_ABORT stops with clock held low
  // after the fifth falling edge.
  task automatic device_run(input int mode);
    logic [10:0] seen;
    int n;
    n = 0;
    while (!ps2_clk_oe && n < 5000) begin wait_cyc(1); n++; end
    while (ps2_clk_oe && n < 5000) begin wait_cyc(1); n++; end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL dev_request no request-to-send within 5000 cycles");
      return;
    end
    wait_cyc($urandom_range(20, 200));
    seen[0] = ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (mode == DEV_ABORT && i == 5) begin
        wait_cyc(100);
        return;
      end
      wait_cyc(HALF);
      dev_clk_low = 1'b0;
      #1 seen[i] = ps2_data_in;
      if (i == 10 && mode == DEV_ACK) begin
        wait_cyc(HALF / 2);
        dev_data_low = 1'b1;
        wait_cyc(HALF / 2);
      end else begin
        wait_cyc(HALF);
      end
    end
    seen_q.push_back(seen);
    dev_clk_low = 1'b1;
    wait_cyc(HALF);
    dev_clk_low = 1'b0;
    wait_cyc(HALF / 2);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_outstanding", exp_q.size(), 0);
    wait_cyc(5);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_980_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, e0, a0, n;
    logic [7:0] rb;

    // Reset values
    @(posedge clock);
    @(negedge clock);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_error", 32'(tx_error), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    exp_kind_next = K_DONE;
    fork
      send_byte(8'hED, 1'b0);
      device_run(DEV_ACK);
    join
    wait_drain(3000);
    check("ed_inhibit_len", last_inh, INHIBIT_CYCLES + 1);
    check("ed_done_once", done_cnt - d0, 1);
    check("ed_no_error", err_cnt - e0, 0);

    // 0xF4 with tx_valid held (0x00) while busy, back-to-back 0x00
    a0 = acc_cnt;
    fork
      send_byte(8'hF4, 1'b1);
      device_run(DEV_ACK);
    join
    n = 0;
    while (acc_cnt - a0 < 2 && n < 500) begin @(negedge clock); n++; end
    tx_valid = 1'b0;
    check("b2b_accepted", acc_cnt - a0, 2);
    check("b2b_accept_cycle", acc_cyc, done_cyc);
    device_run(DEV_ACK);
    wait_drain(3000);
    check("held_valid_frames", acc_cnt - a0, 2);

    // Random byte with ACK
    rb = 8'($urandom_range(0, 255));
    fork
      send_byte(rb, 1'b0);
      device_run(DEV_ACK);
    join
    wait_drain(3000);

    // Device never clocks: first-edge timeout
    e0 = err_cnt;
    exp_kind_next = K_ERR;
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    wait_drain(FIRST_EDGE_CYCLES + 500);
    check("timeout_error_once", err_cnt - e0, 1);
    check("timeout_latency", err_cyc - start_cyc, FIRST_EDGE_CYCLES);

    // Device leaves data high at the ACK edge
    d0 = done_cnt; e0 = err_cnt;
    exp_kind_next = K_ERR_FRAME;
    fork
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      device_run(DEV_NACK);
    join
    wait_drain(3000);
    check("nack_error_once", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);

    // Reset in the middle of SHIFT
    d0 = done_cnt; e0 = err_cnt;
    exp_kind_next = K_NONE;
    fork
      send_byte(8'h55, 1'b0);
      device_run(DEV_ABORT);
    join
    @(negedge clock);
    check("mid_busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("mid_rst_data_oe", 32'(ps2_data_oe), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(tx_ready), 1);
    check("mid_rst_pulses", 32'({tx_done, tx_error}), 0);
    dev_clk_low = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(300);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_error", err_cnt - e0, 0);

    // 0xFF after reset completes normally
    d0 = done_cnt;
    exp_kind_next = K_DONE;
    fork
      send_byte(8'hFF, 1'b0);
      device_run(DEV_ACK);
    join
    wait_drain(3000);
    check("ff_done_once", done_cnt - d0, 1);

    check("final_exp_empty", exp_q.size(), 0);
    check("final_seen_empty", seen_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
